// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD = 4'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Conditional add-3; 4-bit result, no inter-digit carry.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESHOLD) begin
            digit_out = digit_in + ADJ_ADD;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, result and
// sticky overflow registered and presented with a one-cycle done pulse.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [BCD_W-1:0]   work_r;
    logic [WIDTH-1:0]   shift_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_acc_r;

    logic [BCD_W-1:0]   adj_digits;
    logic [BCD_W-1:0]   next_digits;
    logic [WIDTH-1:0]   next_shift;
    logic               carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (work_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adj_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One shift step of {digits, binary}; the bit leaving the top digit is the overflow carry.
    always_comb begin
        {carry_out, next_digits, next_shift} = {adj_digits, shift_r, 1'b0};
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            work_r    <= '0;
            shift_r   <= '0;
            cnt_r     <= '0;
            ovf_acc_r <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_r   <= bin;
                        work_r    <= '0;
                        cnt_r     <= CNT_W'(WIDTH);
                        ovf_acc_r <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                SHIFT: begin
                    work_r    <= next_digits;
                    shift_r   <= next_shift;
                    ovf_acc_r <= ovf_acc_r | carry_out;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        bcd      <= next_digits;
                        overflow <= ovf_acc_r | carry_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: three converter configurations against an arithmetic
// (divide/modulo) reference, directed corner cases plus random values.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // configuration A: WIDTH=8, DIGITS=3
    logic        start_a = 1'b0;
    logic [7:0]  bin_a = 8'd0;
    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    // configuration B: WIDTH=8, DIGITS=2
    logic        start_b = 1'b0;
    logic [7:0]  bin_b = 8'd0;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    // configuration C: WIDTH=16, DIGITS=5
    logic        start_c = 1'b0;
    logic [15:0] bin_c = 16'd0;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return (v >= p);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge (possibly the done cycle), ends at the negedge where done is seen.
    task automatic conv_a(input logic [7:0] v, input bit noise);
        int cyc;
        start_a = 1'b1; bin_a = v;
        @(negedge clk);
        start_a = 1'b0; bin_a = 8'd7;
        check_eq("a_busy", 64'(busy_a), 64'd1);
        cyc = 0;
        while (!done_a && cyc < 20) begin
            if (noise && cyc >= 1 && cyc <= 4) start_a = 1'b1;
            else start_a = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        check_eq("a_latency", 64'(cyc), 64'd8);
        check_eq("a_bcd", 64'(bcd_a), ref_bcd(64'(v), 3));
        check_eq("a_ovf", 64'(ovf_a), 64'(ref_ovf(64'(v), 3)));
        check_eq("a_busy_done", 64'(busy_a), 64'd0);
    endtask

    task automatic conv_b(input logic [7:0] v);
        int cyc;
        start_b = 1'b1; bin_b = v;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("b_latency", 64'(cyc), 64'd8);
        check_eq("b_bcd", 64'(bcd_b), ref_bcd(64'(v), 2));
        check_eq("b_ovf", 64'(ovf_b), 64'(ref_ovf(64'(v), 2)));
    endtask

    task automatic conv_c(input logic [15:0] v);
        int cyc;
        start_c = 1'b1; bin_c = v;
        @(negedge clk);
        start_c = 1'b0;
        cyc = 0;
        while (!done_c && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("c_latency", 64'(cyc), 64'd16);
        check_eq("c_bcd", 64'(bcd_c), ref_bcd(64'(v), 5));
        check_eq("c_ovf", 64'(ovf_c), 64'(ref_ovf(64'(v), 5)));
    endtask

    initial begin
        int extra;
        logic [11:0] held;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_done", 64'(done_a), 64'd0);
        check_eq("rst_bcd", 64'(bcd_a), 64'd0);
        check_eq("rst_ovf", 64'(ovf_a), 64'd0);

        // 255, then stability and single-cycle done
        conv_a(8'd255, 1'b0);
        held = bcd_a;
        @(negedge clk);
        check_eq("a_done_pulse", 64'(done_a), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("a_bcd_hold", 64'(bcd_a), 64'(held));

        // back-to-back: second start issued in the done cycle
        conv_a(8'd0, 1'b0);
        conv_a(8'd99, 1'b0);
        @(negedge clk);

        // starts while busy are ignored
        conv_a(8'd200, 1'b1);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check_eq("a_no_extra_done", 64'(extra), 64'd0);

        // reset mid-conversion
        start_a = 1'b1; bin_a = 8'd123;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check_eq("rst_abort_done", 64'(extra), 64'd0);
        check_eq("rst_abort_busy", 64'(busy_a), 64'd0);
        check_eq("rst_abort_bcd", 64'(bcd_a), 64'd0);
        conv_a(8'd9, 1'b0);
        @(negedge clk);

        // reset wins over simultaneous start
        rst = 1'b1; start_a = 1'b1; bin_a = 8'd77;
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0;
        check_eq("rst_vs_start_busy", 64'(busy_a), 64'd0);
        check_eq("rst_vs_start_bcd", 64'(bcd_a), 64'd0);
        @(negedge clk);

        // exhaustive sweep, back-to-back
        for (int v = 0; v < 256; v++) conv_a(8'(v), 1'b0);
        @(negedge clk);

        // DIGITS=2 overflow and recovery
        conv_b(8'd255);
        @(negedge clk);
        conv_b(8'd42);
        for (int i = 0; i < 16; i++) conv_b(8'($urandom_range(255, 0)));

        // WIDTH=16, DIGITS=5
        @(negedge clk);
        conv_c(16'd65535);
        conv_c(16'd0);
        conv_c(16'd10000);
        for (int i = 0; i < 24; i++) conv_c(16'($urandom_range(65535, 0)));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It takes a WIDTH-bit unsigned value on a start strobe and returns DIGITS packed BCD digits with a one-cycle done pulse. It feeds the score and move-counter display path, replacing per-bit combinational correction cascades whose area grows with WIDTH.

## Interface
- WIDTH, 8: binary input width, 1 to 32.
- DIGITS, 3: number of BCD output digits, 1 to 10.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  WIDTH  unsigned value; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd and overflow are valid from this cycle.
- bcd  out  4*DIGITS  packed result, digit 0 in bits [3:0]; holds until the next done.
- overflow  out  1  bin ≥ 10^DIGITS; valid with done and held with bcd.

## Operation
- States: IDLE and SHIFT.
- IDLE with start=1:
  - capture bin into the shift register;
  - clear the working BCD register;
  - load the bit counter with WIDTH;
  - clear the sticky overflow flag;
  - go to SHIFT.
- SHIFT, each cycle:
  - Adjust every working digit: if the digit ≥ 5, add 3, otherwise leave it (4-bit result, no carry between digits).
  - Shift the concatenation {digits, binary} left by 1. The binary MSB enters digit 0 bit 0.
  - The bit shifted out of the top digit's bit 3 is ORed into the sticky overflow flag.
  - Decrement the counter.
- Last iteration (counter = 1):
  - load bcd and overflow from the combinational next values;
  - pulse done;
  - return to IDLE.
- start while busy=1 is ignored; there is no queueing.
- On overflow, bcd holds the true low DIGITS decimal digits, i.e. bin mod 10^DIGITS.
- Reset values: state IDLE, busy=0, done=0, bcd=0, overflow=0. Working registers and counter are cleared.
- rst asserted mid-conversion aborts the conversion with no done pulse. rst wins over a simultaneous start.

## Timing
- Let start be accepted at edge t0.
  - busy is high from t0.
  - WIDTH shift iterations occur at edges t0+1 … t0+WIDTH.
  - At edge t0+WIDTH: done=1, bcd and overflow update, and busy=0.
- Latency is WIDTH cycles from the accepted start edge to done being visible.
- The next start is accepted at edge t0+WIDTH+1, including while done is high. Peak throughput is one conversion per WIDTH+1 cycles.
- done is high for exactly one cycle per accepted start.
- bcd and overflow change only on done or rst.
- No combinational path from any input to any output.

## Structure
Shared package bcd_pkg holds:
- BCD_DIGIT_W = 4;
- ADJ_THRESHOLD = 5;
- ADJ_ADD = 3;
- the state typedef {IDLE, SHIFT}.

Sub-module bcd_digit_adj is the single-digit combinational ≥5 → +3 correction. bin2bcd_seq instantiates it DIGITS times in a generate loop. All sequential logic stays in bin2bcd_seq.

## Test plan
- WIDTH=8, DIGITS=3, bin=255, start for one cycle -> busy for 8 cycles, then done pulse with bcd=0x255 and overflow=0. bcd is stable afterwards.
- WIDTH=8, DIGITS=3, bin=0 then bin=99 back-to-back (second start in the done cycle) -> bcd=0x000, then bcd=0x099. Second done exactly 9 cycles after the first.
- WIDTH=8, DIGITS=2, bin=255 -> done with bcd=0x55, overflow=1. A following conversion of bin=42 -> bcd=0x42, overflow=0.
- bin=200 accepted; bin=7 with start asserted on cycles 2–5 -> exactly one done, bcd=0x200; the later starts are ignored.
- rst asserted at cycle 4 of a conversion of 123 -> no done, all outputs 0. A new start for bin=9 -> bcd=0x009 after 8 cycles.
- WIDTH=16, DIGITS=5, bin=65535 -> done 16 cycles after start, bcd=0x65535. Exhaustive sweep 0…255 at WIDTH=8 matches a reference model.
